// File: rtl/subpel_sched.sv
// Issue scheduler for the sub-pixel interpolator: drives the horizontal pass and
// the three vertical source passes, then tags results as they leave the FIR stages.
module subpel_sched #(
    parameter int NUM_PIXEL = 8,
    parameter int H_ROWS    = 15,
    parameter int FIR_LAT   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       flush,
    output logic       busy,
    output logic       done,
    output logic [7:0] row_cnt,
    output logic [1:0] src_sel,
    output logic       shift_en,
    output logic       out_we,
    output logic [7:0] out_idx
);

    typedef enum logic [2:0] {IDLE, HPASS, HWAIT, VPASS, DRAIN, DONE} state_t;

    localparam logic [7:0] ROW_LAST_H = 8'(H_ROWS - 1);
    localparam logic [7:0] ROW_LAST_V = 8'(NUM_PIXEL - 1);
    localparam logic [7:0] IDX_LAST   = 8'(4 * NUM_PIXEL - 1);
    localparam logic [7:0] INT_FIRST  = 8'd3;
    localparam logic [7:0] INT_LAST   = 8'(3 + NUM_PIXEL - 1);
    localparam logic [2:0] WAIT_LAST  = 3'(FIR_LAT - 1);

    state_t     state_q;
    logic [2:0] wait_q;
    logic       busy_q, done_q, shift_en_q, out_we_q;
    logic [7:0] row_cnt_q, out_idx_q;
    logic [1:0] src_sel_q;

    logic       iss_v, iss_h;
    logic       emerge_v_d, emerge_h_d;
    logic [7:0] emerge_row_d;

    assign iss_v = (state_q == HPASS) || (state_q == VPASS);
    assign iss_h = (state_q == HPASS);

    // The output registers form the last stage of the tag line, so the line
    // itself only needs FIR_LAT-1 stages ahead of them.
    generate
        if (FIR_LAT > 1) begin : g_line
            localparam int D = FIR_LAT - 1;
            logic [D-1:0] v_q, h_q;
            logic [7:0]   row_q [D];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v_q <= '0;
                    h_q <= '0;
                    for (int i = 0; i < D; i++) row_q[i] <= '0;
                end else if (flush) begin
                    v_q <= '0;
                    h_q <= '0;
                end else begin
                    v_q[0]   <= iss_v;
                    h_q[0]   <= iss_h;
                    row_q[0] <= row_cnt_q;
                    for (int i = 1; i < D; i++) begin
                        v_q[i]   <= v_q[i-1];
                        h_q[i]   <= h_q[i-1];
                        row_q[i] <= row_q[i-1];
                    end
                end
            end

            assign emerge_v_d   = v_q[D-1];
            assign emerge_h_d   = h_q[D-1];
            assign emerge_row_d = row_q[D-1];
        end else begin : g_direct
            assign emerge_v_d   = iss_v;
            assign emerge_h_d   = iss_h;
            assign emerge_row_d = row_cnt_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            shift_en_q <= 1'b0;
            out_we_q   <= 1'b0;
            row_cnt_q  <= '0;
            src_sel_q  <= '0;
            out_idx_q  <= '0;
        end else if (flush) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            shift_en_q <= 1'b0;
            out_we_q   <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            shift_en_q <= emerge_v_d && emerge_h_d;
            out_we_q   <= emerge_v_d && (!emerge_h_d ||
                          (emerge_row_d >= INT_FIRST && emerge_row_d <= INT_LAST));
            // Saturate at the last slot so a stray write can never wrap the index.
            if (out_we_q && out_idx_q != IDX_LAST)
                out_idx_q <= out_idx_q + 8'd1;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= HPASS;
                        busy_q    <= 1'b1;
                        row_cnt_q <= '0;
                        src_sel_q <= '0;
                        out_idx_q <= '0;
                    end
                end
                HPASS: begin
                    if (row_cnt_q == ROW_LAST_H) begin
                        state_q <= HWAIT;
                        wait_q  <= '0;
                    end else begin
                        row_cnt_q <= row_cnt_q + 8'd1;
                    end
                end
                HWAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        state_q   <= VPASS;
                        row_cnt_q <= '0;
                        src_sel_q <= 2'd1;
                    end else begin
                        wait_q <= wait_q + 3'd1;
                    end
                end
                VPASS: begin
                    if (row_cnt_q == ROW_LAST_V) begin
                        if (src_sel_q == 2'd3) begin
                            state_q <= DRAIN;
                            wait_q  <= '0;
                        end else begin
                            row_cnt_q <= '0;
                            src_sel_q <= src_sel_q + 2'd1;
                        end
                    end else begin
                        row_cnt_q <= row_cnt_q + 8'd1;
                    end
                end
                DRAIN: begin
                    if (wait_q == WAIT_LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 3'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign row_cnt  = row_cnt_q;
    assign src_sel  = src_sel_q;
    assign shift_en = shift_en_q;
    assign out_we   = out_we_q;
    assign out_idx  = out_idx_q;

endmodule

// File: tb/tb_subpel_sched.sv
// Scoreboard bench for subpel_sched: three instances (FIR_LAT 2, 1, 3) share one
// stimulus; instance 0 carries the detailed checks.
module tb_subpel_sched;

    localparam int NP   = 8;
    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst, start, flush;
    logic       busy_w  [NDUT];
    logic       done_w  [NDUT];
    logic       shift_w [NDUT];
    logic       we_w    [NDUT];
    logic [7:0] row_w   [NDUT];
    logic [7:0] idx_w   [NDUT];
    logic [1:0] src_w   [NDUT];

    int vectors     = 0;
    int miscompares = 0;
    int sb_q [NDUT][$];

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            subpel_sched #(
                .NUM_PIXEL(NP),
                .H_ROWS   (15),
                .FIR_LAT  (gi == 0 ? 2 : (gi == 1 ? 1 : 3))
            ) u_dut (
                .clk     (clk),
                .rst     (rst),
                .start   (start),
                .flush   (flush),
                .busy    (busy_w[gi]),
                .done    (done_w[gi]),
                .row_cnt (row_w[gi]),
                .src_sel (src_w[gi]),
                .shift_en(shift_w[gi]),
                .out_we  (we_w[gi]),
                .out_idx (idx_w[gi])
            );
        end
    endgenerate

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input int k);
        chk({tag, "_busy"},  32'(busy_w[k]),  32'd0);
        chk({tag, "_done"},  32'(done_w[k]),  32'd0);
        chk({tag, "_shift"}, 32'(shift_w[k]), 32'd0);
        chk({tag, "_we"},    32'(we_w[k]),    32'd0);
        chk({tag, "_row"},   32'(row_w[k]),   32'd0);
        chk({tag, "_src"},   32'(src_w[k]),   32'd0);
        chk({tag, "_idx"},   32'(idx_w[k]),   32'd0);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    // Full block on every instance: writes, shift pulses, done timing, source order.
    task automatic nominal(input string tag);
        int shifts [NDUT];
        int wes    [NDUT];
        int dones  [NDUT];
        int vexp_q [$];
        for (int k = 0; k < NDUT; k++) begin
            shifts[k] = 0; wes[k] = 0; dones[k] = 0;
            sb_q[k].delete();
            for (int i = 0; i < 4 * NP; i++) sb_q[k].push_back(i);
        end
        for (int s = 1; s <= 3; s++)
            for (int r = 0; r < NP; r++) vexp_q.push_back((s << 8) | r);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_rise"}, 32'(busy_w[0]), 32'd1);
        for (int cyc = 1; cyc <= 50; cyc++) begin
            if (cyc > 1) tick();
            for (int k = 0; k < NDUT; k++) begin
                if (shift_w[k]) shifts[k]++;
                if (we_w[k]) begin
                    wes[k]++;
                    if (sb_q[k].size() == 0) chk({tag, "_we_extra"}, 32'(wes[k]), 32'(4 * NP));
                    else chk({tag, "_out_idx"}, 32'(idx_w[k]), 32'(sb_q[k].pop_front()));
                end
                if (done_w[k]) begin
                    dones[k]++;
                    chk({tag, "_done_cyc"}, 32'(cyc), 32'(44 + 2 * (lat_of(k) - 2)));
                end
            end
            if (cyc >= 18 && cyc <= 41 && vexp_q.size() != 0)
                chk({tag, "_src_row"}, 32'({src_w[0], row_w[0]}), 32'(vexp_q.pop_front()));
        end
        for (int k = 0; k < NDUT; k++) begin
            chk({tag, "_shift_cnt"}, 32'(shifts[k]), 32'd15);
            chk({tag, "_we_cnt"},    32'(wes[k]),    32'(4 * NP));
            chk({tag, "_done_cnt"},  32'(dones[k]),  32'd1);
            chk({tag, "_sb_left"},   32'(sb_q[k].size()), 32'd0);
            chk({tag, "_busy_end"},  32'(busy_w[k]), 32'd0);
        end
        $display("nominal %s: shifts=%0d writes=%0d dones=%0d", tag, shifts[0], wes[0], dones[0]);
    endtask

    task automatic start_held();
        int dcyc [$];
        int wes = 0;
        start = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 89; cyc++) begin
            if (cyc > 1) tick();
            if (we_w[0]) wes++;
            if (done_w[0]) dcyc.push_back(cyc);
        end
        start = 1'b0;
        chk("held_done_cnt", 32'(dcyc.size()), 32'd2);
        if (dcyc.size() >= 2) begin
            chk("held_done0", 32'(dcyc[0]), 32'd44);
            chk("held_done1", 32'(dcyc[1]), 32'd89);
        end
        chk("held_we_cnt", 32'(wes), 32'(8 * NP));
        tick();
        tick();
        chk("held_busy_end", 32'(busy_w[0]), 32'd0);
        pulse_flush();
        $display("start held: dones=%0d writes=%0d", dcyc.size(), wes);
    endtask

    task automatic flush_mid_vpass();
        int wes_pre = 0;
        int wes_post = 0;
        int dones = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            if (cyc > 1) tick();
            if (we_w[0]) wes_pre++;
        end
        pulse_flush();
        for (int k = 0; k < NDUT; k++) chk("flush_busy", 32'(busy_w[k]), 32'd0);
        for (int cyc = 26; cyc <= 60; cyc++) begin
            for (int k = 0; k < NDUT; k++) begin
                if (we_w[k]) wes_post++;
                if (done_w[k]) dones++;
            end
            tick();
        end
        chk("flush_we_pre", 32'(wes_pre), 32'd14);
        chk("flush_we_post", 32'(wes_post), 32'd0);
        chk("flush_done", 32'(dones), 32'd0);
        $display("flush mid-vpass: writes before=%0d after=%0d dones=%0d", wes_pre, wes_post, dones);
    endtask

    task automatic reset_mid_hpass();
        int stray = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 2; cyc <= 5; cyc++) tick();
        chk("rst_pre_busy", 32'(busy_w[0]), 32'd1);
        #2 rst = 1'b0;
        #1 check_idle("rst_async", 0);
        #2 rst = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            for (int k = 0; k < NDUT; k++)
                if (we_w[k] || shift_w[k] || done_w[k] || busy_w[k]) stray++;
        end
        chk("rst_no_resume", 32'(stray), 32'd0);
        $display("async reset mid-hpass: stray activity=%0d", stray);
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) check_idle("reset", k);
        $display("reset: outputs checked at reset values");
        @(negedge clk);
        rst = 1'b1;
        tick();

        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        chk("flush_start_busy", 32'(busy_w[0]), 32'd0);
        tick();
        chk("flush_start_busy2", 32'(busy_w[0]), 32'd0);
        $display("flush+start in idle: busy=%0d", busy_w[0]);

        nominal("nom");
        start_held();
        flush_mid_vpass();
        reset_mid_hpass();
        nominal("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
